// File: rtl/synth_cmd_pkg.sv
// Shared opcodes, decoder states and packet lengths for the SPI synth command path.
// Defining CMD_CHECKSUM_EN switches to 4-byte packets with a trailing XOR byte.
package synth_cmd_pkg;

  localparam logic [7:0] OP_NOTE_ON  = 8'h90;
  localparam logic [7:0] OP_NOTE_OFF = 8'h80;
  localparam logic [7:0] OP_REG_WR   = 8'hB0;

  localparam int PKT_LEN_PLAIN = 3;
  localparam int PKT_LEN_CHK   = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_OP1  = 3'd1,
    ST_OP2  = 3'd2,
    ST_CHK  = 3'd3,
    ST_EMIT = 3'd4
  } state_t;

`ifdef CMD_CHECKSUM_EN
  localparam int     PKT_LEN  = PKT_LEN_CHK;
  localparam state_t ST_FINAL = ST_CHK;
`else
  localparam int     PKT_LEN  = PKT_LEN_PLAIN;
  localparam state_t ST_FINAL = ST_OP2;
`endif

  function automatic logic is_opcode(input logic [7:0] b);
    return (b == OP_NOTE_ON) || (b == OP_NOTE_OFF) || (b == OP_REG_WR);
  endfunction

endpackage

// File: rtl/spi_cmd_decoder_if.sv
// Byte-in / command-out bundle between the SPI receiver, the decoder and its consumers.
interface spi_cmd_decoder_if
  import synth_cmd_pkg::*;
#(
  parameter int REG_AW = 8
);
  // No backpressure: every *_valid / strobe is a one-cycle pulse that the
  // receiving side must take in the cycle it is high; there is no ready.
  logic [7:0]        i_byte;
  logic              i_byte_valid;
  logic              i_frame_end;
  logic              o_note_valid;
  logic              o_note_on;
  logic [6:0]        o_note;
  logic [6:0]        o_velocity;
  logic              o_reg_wr;
  logic [REG_AW-1:0] o_reg_addr;
  logic [7:0]        o_reg_data;
  logic              o_err;
  state_t            dbg_state;

  modport master (
    output i_byte, i_byte_valid, i_frame_end,
    input  o_note_valid, o_note_on, o_note, o_velocity,
    input  o_reg_wr, o_reg_addr, o_reg_data, o_err, dbg_state
  );

  modport slave (
    input  i_byte, i_byte_valid, i_frame_end,
    output o_note_valid, o_note_on, o_note, o_velocity,
    output o_reg_wr, o_reg_addr, o_reg_data, o_err, dbg_state
  );
endinterface

// File: rtl/byte_gap_timer.sv
// Inter-byte gap counter: cleared by each byte, counts while a packet is open,
// saturates at GAP_CYCLES and flags expiry.
module byte_gap_timer #(
  parameter int GAP_CYCLES = 4096
) (
  input  logic i_sys_clk,
  input  logic i_rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);
  localparam int            CW    = $clog2(GAP_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(GAP_CYCLES);

  logic [CW-1:0] count;

  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count <= '0;
    end else if (clear || !run) begin
      count <= '0;
    end else if (count != LIMIT) begin
      count <= count + CW'(1);
    end
  end

  assign expired = run && (count == LIMIT);
endmodule

// File: rtl/spi_cmd_decoder.sv
// Turns SPI receiver bytes into note-on/off and register-write commands; bad,
// truncated or stalled packets are dropped with an o_err pulse. Optional: CMD_CHECKSUM_EN.
module spi_cmd_decoder
  import synth_cmd_pkg::*;
#(
  parameter int GAP_CYCLES = 4096,
  parameter int REG_AW     = 8
) (
  input  logic             i_sys_clk,
  input  logic             i_rst_n,
  spi_cmd_decoder_if.slave bus
);
  state_t     state;
  logic [7:0] op_q;
  logic [7:0] b1_q;
  logic [7:0] fin_b2;
  logic       b1_ok;
  logic       b2_ok;
  logic       final_ok;
  logic       do_emit;
  logic       gap_expired;
  logic       timer_run;

`ifdef CMD_CHECKSUM_EN
  logic [7:0] b2_q;
  assign fin_b2   = b2_q;
  assign final_ok = (bus.i_byte == (op_q ^ b1_q ^ b2_q));
`else
  assign fin_b2   = bus.i_byte;
  assign final_ok = b2_ok;
`endif

  // Note operands are 7-bit; register addresses must fit in REG_AW bits.
  assign b1_ok = (op_q == OP_REG_WR) ? ((bus.i_byte >> REG_AW) == 8'd0) : !bus.i_byte[7];
  assign b2_ok = (op_q == OP_REG_WR) || !bus.i_byte[7];

  assign do_emit   = bus.i_byte_valid && (state == ST_FINAL) && final_ok;
  assign timer_run = (state == ST_OP1) || (state == ST_OP2) || (state == ST_CHK);
  assign bus.dbg_state = state;

  byte_gap_timer #(.GAP_CYCLES(GAP_CYCLES)) u_gap_timer (
    .i_sys_clk (i_sys_clk),
    .i_rst_n   (i_rst_n),
    .clear     (bus.i_byte_valid),
    .run       (timer_run),
    .expired   (gap_expired)
  );

  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state            <= ST_IDLE;
      op_q             <= '0;
      b1_q             <= '0;
`ifdef CMD_CHECKSUM_EN
      b2_q             <= '0;
`endif
      bus.o_note_valid <= 1'b0;
      bus.o_note_on    <= 1'b0;
      bus.o_note       <= '0;
      bus.o_velocity   <= '0;
      bus.o_reg_wr     <= 1'b0;
      bus.o_reg_addr   <= '0;
      bus.o_reg_data   <= '0;
      bus.o_err        <= 1'b0;
    end else begin
      bus.o_note_valid <= 1'b0;
      bus.o_reg_wr     <= 1'b0;
      bus.o_err        <= 1'b0;

      // A byte arriving with frame end only survives if it completes the packet.
      case (state)
        ST_IDLE: begin
          if (bus.i_byte_valid) begin
            if (is_opcode(bus.i_byte) && !bus.i_frame_end) begin
              op_q  <= bus.i_byte;
              state <= ST_OP1;
            end else begin
              bus.o_err <= 1'b1;
            end
          end
        end
        ST_OP1: begin
          if (bus.i_byte_valid) begin
            if (b1_ok && !bus.i_frame_end) begin
              b1_q  <= bus.i_byte;
              state <= ST_OP2;
            end else begin
              bus.o_err <= 1'b1;
              state     <= ST_IDLE;
            end
          end else if (bus.i_frame_end || gap_expired) begin
            bus.o_err <= 1'b1;
            state     <= ST_IDLE;
          end
        end
`ifdef CMD_CHECKSUM_EN
        ST_OP2: begin
          if (bus.i_byte_valid) begin
            if (b2_ok && !bus.i_frame_end) begin
              b2_q  <= bus.i_byte;
              state <= ST_CHK;
            end else begin
              bus.o_err <= 1'b1;
              state     <= ST_IDLE;
            end
          end else if (bus.i_frame_end || gap_expired) begin
            bus.o_err <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        ST_CHK: begin
`else
        ST_OP2: begin
`endif
          if (bus.i_byte_valid) begin
            if (!final_ok) begin
              bus.o_err <= 1'b1;
              state     <= ST_IDLE;
            end
          end else if (bus.i_frame_end || gap_expired) begin
            bus.o_err <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        ST_EMIT: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      if (do_emit) begin
        state <= ST_EMIT;
        if (op_q == OP_REG_WR) begin
          bus.o_reg_wr   <= 1'b1;
          bus.o_reg_addr <= b1_q[REG_AW-1:0];
          bus.o_reg_data <= fin_b2;
        end else begin
          // Note-on with zero velocity is reported as note-off.
          bus.o_note_valid <= 1'b1;
          bus.o_note_on    <= (op_q == OP_NOTE_ON) && (fin_b2[6:0] != 7'd0);
          bus.o_note       <= b1_q[6:0];
          bus.o_velocity   <= fin_b2[6:0];
        end
      end
    end
  end
endmodule

// File: doc/spi_cmd_decoder.md
# spi_cmd_decoder

- Parses the byte stream produced by the SPI slave receiver into synth commands: note-on, note-off and control-register writes.
- Sits directly downstream of the SPI byte receiver, in the system clock domain, and feeds the voice allocator and the control register bank.
- Frames are fixed-length opcode/operand packets.
- Malformed, truncated or stalled packets are dropped and flagged.

## Interface
Parameters:
- GAP_CYCLES, 4096: max `i_sys_clk` cycles allowed between bytes of one packet before abort.
- REG_AW, 8: control-register address width (≤8).

Ports:
- i_sys_clk  in  1  system clock; all logic on rising edge.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_byte  in  8  received byte.
- i_byte_valid  in  1  one-cycle strobe, `i_byte` valid.
- i_frame_end  in  1  one-cycle strobe, slave-select deasserted.
- o_note_valid  out  1  one-cycle pulse, note fields valid.
- o_note_on  out  1  1 = note-on, 0 = note-off.
- o_note  out  7  note number.
- o_velocity  out  7  velocity.
- o_reg_wr  out  1  one-cycle register write strobe.
- o_reg_addr  out  REG_AW  register address.
- o_reg_data  out  8  register data.
- o_err  out  1  one-cycle pulse on any dropped packet.

## Operation
Opcodes (byte 0):
- 0x90: note-on.
- 0x80: note-off.
- 0xB0: register write.
- Any other value: error. Pulse `o_err` and stay in IDLE.

Operand bytes:
- Byte 1: note number or register address.
- Byte 2: velocity or register data.
- Note operands: bit 7 must be 0, else error.
- Register address: upper bits above REG_AW must be 0, else error.
- Register data: unrestricted.

Commands:
- Note-on with velocity 0 is emitted as note-off, `o_velocity`=0.

States:
- IDLE → OP1 on a valid opcode.
- OP1 → OP2 on a valid operand.
- OP2 → EMIT on the final byte (→ CHK when checksum is enabled).
- EMIT → IDLE.

Gap timer:
- Counter cleared on every accepted byte; runs in OP1/OP2/CHK.
- On reaching GAP_CYCLES: pulse `o_err` and return to IDLE.

Frame end:
- `i_frame_end` in OP1/OP2/CHK: pulse `o_err`, return to IDLE.
- `i_frame_end` in IDLE: ignored.

Byte and frame end in the same cycle:
- The byte is processed first.
- If that byte completes the packet, the command is emitted with no error.
- Otherwise abort with `o_err`.

`i_byte_valid` during EMIT is impossible; the receiver spaces bytes by ≥8 SPI clocks. The decoder ignores it.

Output values:
- Data outputs hold their last emitted values between strobes.
- Reset value of every output is 0.

## Timing
- Command strobe (`o_note_valid` / `o_reg_wr`) asserts exactly 1 cycle after the cycle in which the final byte's `i_byte_valid` is sampled.
- Command strobe is high for exactly 1 cycle.
- Data outputs update in the same cycle as the strobe.
- `o_err` asserts 1 cycle after the offending byte, frame-end or timeout cycle, for 1 cycle.
- At most one strobe per cycle.
- Next opcode accepted the cycle after EMIT.
- Async reset mid-packet: return to IDLE immediately, clear timer and outputs, no strobe.

## Configuration
CMD_CHECKSUM_EN, when defined:
- Every packet carries a 4th byte equal to the XOR of bytes 0–2, checked in state CHK.
- Match: emit the command.
- Mismatch: pulse `o_err` and emit nothing.
- Command latency is counted from the checksum byte.

Undefined:
- 3-byte packets, CHK state absent.

## Structure
Package `synth_cmd_pkg`:
- Opcode constants (OP_NOTE_ON=0x90, OP_NOTE_OFF=0x80, OP_REG_WR=0xB0).
- State enum.
- Packet length constants.

Sub-module `byte_gap_timer`:
- Loadable counter, width $clog2(GAP_CYCLES+1), with clear and expire outputs.
- Instantiated once.

## Test plan
- Bytes 0x90,0x3C,0x64 → one `o_note_valid` pulse, `o_note_on`=1, `o_note`=0x3C, `o_velocity`=0x64; `o_err` stays 0.
- Bytes 0x90,0x40,0x00 → `o_note_on`=0, `o_velocity`=0.
- Bytes 0xB0,0x12,0xFF → `o_reg_wr` pulse, addr 0x12, data 0xFF.
- Bytes 0x90,0x3C then `i_frame_end` → `o_err` pulse, no note; next 0x80,0x3C,0x10 decodes normally.
- Bytes 0x90,0x3C then idle for GAP_CYCLES → `o_err` at timeout.
- Opcode 0x55 → `o_err`; 0x90,0x85,... → `o_err` on byte 1.
- With CMD_CHECKSUM_EN: 0x90,0x3C,0x64,0xC8 → note emitted; 0xC9 → `o_err` and no note.
